// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: operand forwarding,
// load-use bubbles, taken-branch flushes and a global freeze while data memory is busy.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
        logic              memtoreg;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              regwrite;
    } wr_stage_t;

    ex_stage_t        ex_q, ex_d;
    wr_stage_t        mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    // Register 0 is hard-wired to zero, so a write to it never produces a value.
    function automatic logic hits(input wr_stage_t s, input logic [REG_AW-1:0] src);
        return s.valid && s.regwrite && (s.dest != '0) && (s.dest == src);
    endfunction

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hits(mem_q, ex_q.rs)) begin
            fwd_a = 2'b01;
        end else if (hits(wb_q, ex_q.rs)) begin
            fwd_a = 2'b10;
        end
        if (hits(mem_q, ex_q.rt)) begin
            fwd_b = 2'b01;
        end else if (hits(wb_q, ex_q.rt)) begin
            fwd_b = 2'b10;
        end
    end

    assign load_use = ex_q.valid && ex_q.memtoreg && (ex_q.dest != '0) && id_valid &&
                      ((id_uses_rs && (id_rs == ex_q.dest)) ||
                       (id_uses_rt && (id_rt == ex_q.dest)));

    // Priority: reset, memory freeze, taken branch, load-use, normal flow.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_en     = 1'b0;
        if (!reset && !mem_busy) begin
            pipe_en = 1'b1;
            if (branch_taken) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pipe_en) begin
            wb_d  = mem_q;
            mem_d = {ex_q.valid, ex_q.dest, ex_q.regwrite};
            ex_d  = {id_valid && !idex_bubble, id_rs, id_rt, id_dest, id_regwrite, id_memtoreg};
        end
        // A stall cycle is either a freeze or a load-use bubble that no branch overrode.
        if (mem_busy || (idex_bubble && !ifid_flush)) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
        if (ifid_flush && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
